// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding select and load-use stall control for
// the 5-stage pipeline. A shadow copy of the EX and MEM destination records
// sits beside the datapath. EX/MEM feeds select 01 and MEM/WB feeds select 10.
// An instruction whose producer has already reached WB reads the register
// file in ID, so forwarding needs no WB record.

module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] SEL_WB  = 2'b10;  // MEM/WB writeback data

    // EX and MEM shadow records
    logic              ex_v, ex_rw, ex_mr;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_v, mem_rw;
    logic [REG_AW-1:0] mem_rd;

    logic ex_wr_rs1, ex_wr_rs2, mem_wr_rs1, mem_wr_rs2;
    logic [1:0] sel_a_nxt, sel_b_nxt;

    // A record "writes r" only for a live, writing, non-x0 destination
    always_comb begin
        ex_wr_rs1  = ex_v  & ex_rw  & (ex_rd  == id_rs1) & (id_rs1 != '0);
        ex_wr_rs2  = ex_v  & ex_rw  & (ex_rd  == id_rs2) & (id_rs2 != '0);
        mem_wr_rs1 = mem_v & mem_rw & (mem_rd == id_rs1) & (id_rs1 != '0);
        mem_wr_rs2 = mem_v & mem_rw & (mem_rd == id_rs2) & (id_rs2 != '0);
    end

    // Load-use hazard: the load in EX has no data until it leaves MEM
    always_comb begin
        stall = id_valid & ~flush & ex_v & ex_mr & ex_rw & (ex_rd != '0) &
                ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
    end

    // Select codes for the instruction about to enter EX; EX is the youngest producer
    always_comb begin
        sel_a_nxt = SEL_RF;
        sel_b_nxt = SEL_RF;
        if (id_valid && id_use_rs1) begin
            if (ex_wr_rs1)       sel_a_nxt = SEL_MEM;
            else if (mem_wr_rs1) sel_a_nxt = SEL_WB;
        end
        if (id_valid && id_use_rs2) begin
            if (ex_wr_rs2)       sel_b_nxt = SEL_MEM;
            else if (mem_wr_rs2) sel_b_nxt = SEL_WB;
        end
    end

    // Shadow pipeline advance, select registers and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v        <= 1'b0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            ex_rd       <= '0;
            mem_v       <= 1'b0;
            mem_rw      <= 1'b0;
            mem_rd      <= '0;
            fwd_a_sel   <= SEL_RF;
            fwd_b_sel   <= SEL_RF;
            stall_count <= '0;
        end else if (!hold) begin
            mem_v  <= ex_v;
            mem_rw <= ex_rw;
            mem_rd <= ex_rd;
            if (flush || stall) begin
                // Bubble into EX; stall already excludes flush so counting is exact
                ex_v      <= 1'b0;
                ex_rw     <= 1'b0;
                ex_mr     <= 1'b0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
                if (stall && (stall_count != '1))
                    stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ex_v      <= id_valid;
                ex_rw     <= id_reg_write;
                ex_mr     <= id_mem_read;
                ex_rd     <= id_rd;
                fwd_a_sel <= sel_a_nxt;
                fwd_b_sel <= sel_b_nxt;
            end
        end
    end

    assign ex_valid = ex_v;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl, built with a 4-bit stall counter so
// that saturation is reachable quickly.

module tb_fwd_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold, flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic              stall, ex_valid;
    logic [CNT_W-1:0]  stall_count;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
        .ex_valid(ex_valid), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic do_reset();
        hold = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        hold = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0;
        #3;
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_sel_a got=%b exp=00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_sel_b got=%b exp=00", fwd_b_sel); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_alu_chain();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 0);   // add x5
        step();
        set_id(1, 5, 1, 0, 0, 6, 1, 0);   // reads x5
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", stall); end
        step();
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL alu_sel_a got=%b exp=01", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL alu_sel_b got=%b exp=00", fwd_b_sel); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL alu_ex_valid got=%b exp=1", ex_valid); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL alu_count got=%0d exp=0", stall_count); end
    endtask

    task automatic test_distance2();
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0);   // produce x7
        step();
        set_id(1, 1, 1, 2, 1, 8, 1, 0);   // unrelated
        step();
        set_id(1, 9, 1, 7, 1, 10, 1, 0);  // rs2=x7
        step();
        checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL dist2_sel_b got=%b exp=10", fwd_b_sel); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL dist2_sel_a got=%b exp=00", fwd_a_sel); end
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0);
        step();
        set_id(1, 0, 0, 0, 0, 7, 1, 0);   // EX and MEM both write x7
        step();
        set_id(1, 0, 0, 7, 1, 11, 1, 0);
        step();
        checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL dist_both_sel_b got=%b exp=01", fwd_b_sel); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);   // lw x3
        step();
        set_id(1, 3, 1, 0, 0, 10, 1, 0);  // uses x3
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got=%b exp=0", stall); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_ex_valid got=%b exp=1", ex_valid); end
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL lu_sel_a got=%b exp=10", fwd_a_sel); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count_after got=%0d exp=1", stall_count); end
    endtask

    task automatic test_x0_unused();
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 0);   // writes x0
        step();
        set_id(1, 0, 1, 0, 1, 12, 1, 0);  // reads x0 on both
        step();
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL x0_sel_a got=%b exp=00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL x0_sel_b got=%b exp=00", fwd_b_sel); end
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1, 1);   // lw x4
        step();
        set_id(1, 1, 1, 4, 0, 13, 1, 0);  // rs2=x4 but unused
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall got=%b exp=0", stall); end
        step();
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL unused_sel_b got=%b exp=00", fwd_b_sel); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL unused_ex_valid got=%b exp=1", ex_valid); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL unused_count got=%0d exp=0", stall_count); end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);
        step();
        flush = 1;
        set_id(1, 3, 1, 0, 0, 10, 1, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        step();
        flush = 0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_ex_valid got=%b exp=0", ex_valid); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", stall_count); end
    endtask

    task automatic test_hold();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);
        step();
        set_id(1, 3, 1, 0, 0, 10, 1, 0);
        hold = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, stall); end
            step();
            checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL hold_ex_valid[%0d] got=%b exp=1", i, ex_valid); end
            checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL hold_count[%0d] got=%0d exp=0", i, stall_count); end
        end
        hold = 0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall got=%b exp=1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL hold_bubble got=%b exp=0", ex_valid); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL hold_count_after got=%0d exp=1", stall_count); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL hold_consumer_valid got=%b exp=1", ex_valid); end
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL hold_sel_a got=%b exp=10", fwd_a_sel); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);   // lw x3
        step();
        set_id(1, 3, 1, 0, 0, 10, 1, 0);  // stall, count -> 1
        step();
        set_id(1, 3, 1, 0, 0, 4, 1, 1);   // lw x4 reading x3 from MEM
        step();
        set_id(1, 0, 0, 4, 1, 14, 1, 0);  // uses x4 -> stall
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL mid_pre_sel_a got=%b exp=10", fwd_a_sel); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall got=%b exp=0", stall); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL mid_ex_valid got=%b exp=0", ex_valid); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL mid_sel_a got=%b exp=00", fwd_a_sel); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", stall_count); end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_id(1, 0, 0, 0, 0, 3, 1, 1);
            step();
            set_id(1, 3, 1, 0, 0, 10, 1, 0);
            step();
            if (i == 14) begin
                checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_at15 got=%0d exp=15", stall_count); end
            end
        end
        checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", stall_count); end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_distance2();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_hold();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
